sevenseg_scan: RTL

- Display stage that sits directly downstream of the mod-M counter chain.
- Takes four 4-bit digit values (BCD outputs of cascaded mod-10 counters) and time-multiplexes them onto one common-anode 7-segment bus.
- Latches a new snapshot of the digits once per scan frame, so a display never shows half of an old count and half of a new one.
- Provides leading-zero blanking, per-digit decimal points, a dash glyph for invalid codes, and a global display enable.

---
 rtl/sevenseg_scan.sv | 112 +++++++++++
 1 files changed

// File: rtl/sevenseg_scan.sv
// Four-digit common-anode 7-segment scanner with a per-frame snapshot of the digits,
// leading-zero blanking, decimal points, a dash for invalid codes and a display enable.
module sevenseg_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        lzb,
  input  logic        en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt;
  logic [1:0]    sel;
  logic [1:0]    sel_next;
  logic [1:0]    disp_sel;
  logic [15:0]   snap_d;
  logic [15:0]   src_d;
  logic [3:0]    snap_dp;
  logic [3:0]    src_dp;
  logic [3:0]    code;
  logic          tick;
  logic          wrap;
  logic          blank;
  logic          live;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    case (c)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  assign tick     = (pcnt == PMAX);
  assign sel_next = sel + 2'd1;
  assign disp_sel = tick ? sel_next : sel;
  assign wrap     = tick && (sel_next == 2'd0);

  // On the frame-wrap edge digit 0 must already show the freshly sampled inputs.
  assign src_d  = wrap ? digits : snap_d;
  assign src_dp = wrap ? dp_in  : snap_dp;

  always_comb begin
    code  = src_d[{disp_sel, 2'b00} +: 4];
    blank = 1'b0;
    if (lzb) begin
      case (disp_sel)
        2'd3:    blank = (src_d[15:12] == 4'd0);
        2'd2:    blank = (src_d[15:8]  == 8'd0);
        2'd1:    blank = (src_d[15:4]  == 12'd0);
        default: blank = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt    <= '0;
      sel     <= 2'd3;
      snap_d  <= '0;
      snap_dp <= '0;
      live    <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        sel  <= sel_next;
        live <= 1'b1;
      end
      if (wrap) begin
        snap_d  <= digits;
        snap_dp <= dp_in;
      end
    end
  end

  // Anodes stay dark until the first tick; en gates them on every edge, seg only moves on ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      if (en && (tick || live)) begin
        an <= ~(4'b0001 << disp_sel);
        dp <= ~src_dp[disp_sel];
      end else begin
        an <= 4'b1111;
        dp <= 1'b1;
      end
      if (tick) seg <= blank ? 7'b1111111 : glyph(code);
    end
  end

endmodule
